// File: rtl/noc_trace_collector_pkg.sv
// Shared definitions for the NoC trace collector.
// Provides log2 and the FIFO entry layout {trace, tile, ts}.
package noc_trace_collector_pkg;

    // Ceiling log2, with a minimum result of 1 so that index fields never collapse.
    function automatic int clog2(input int v);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    // Width of one packed FIFO entry.
    function automatic int entry_w(input int trace_w, input int nt, input int ts_w);
        return trace_w + clog2(nt) + ts_w;
    endfunction

    // Field offsets: the timestamp is in the low bits and the trace word is in the high bits.
    function automatic int ts_lsb();
        return 0;
    endfunction

    function automatic int tile_lsb(input int ts_w);
        return ts_w;
    endfunction

    function automatic int trace_lsb(input int nt, input int ts_w);
        return ts_w + clog2(nt);
    endfunction

endpackage

// File: rtl/noc_trace_collector_arb.sv
// Round-robin arbiter over per-tile hold registers.
// Searches upward from the pointer; the pointer moves past each grant.
module trace_rr_arbiter
    import noc_trace_collector_pkg::*;
#(
    parameter int NT = 4,
    localparam int IW = clog2(NT)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [NT-1:0] req,
    input  logic          allow,
    output logic [NT-1:0] gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          gnt_valid
);

    logic [IW-1:0] ptr_q, ptr_d;

    // Pick the first requester at or after the pointer, wrapping around.
    always_comb begin
        int j;
        gnt       = '0;
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        ptr_d     = ptr_q;
        for (int k = 0; k < NT; k++) begin
            j = int'(ptr_q) + k;
            if (j >= NT) j = j - NT;
            if (allow && !gnt_valid && req[j]) begin
                gnt_valid = 1'b1;
                gnt_idx   = IW'(j);
                gnt[j]    = 1'b1;
            end
        end
        if (gnt_valid) begin
            ptr_d = (gnt_idx == IW'(NT - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    // Pointer register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) ptr_q <= '0;
        else       ptr_q <= ptr_d;
    end

endmodule

// File: rtl/noc_trace_collector.sv
// Trace collector: per-tile hold registers feed an output FIFO through a
// round-robin arbiter, and each event carries a capture timestamp.
module noc_trace_collector
    import noc_trace_collector_pkg::*;
#(
    parameter int NT        = 4,
    parameter int TRACEw    = 32,
    parameter int DEPTH     = 8,
    parameter int TSw       = 16,
    parameter int EDGE_MODE = 0,
    localparam int TW = clog2(NT),
    localparam int CW = clog2(DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic [NT-1:0]        trigger_in,
    input  logic [NT*TRACEw-1:0] trace_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [TRACEw-1:0]    out_trace,
    output logic [TW-1:0]        out_tile,
    output logic [TSw-1:0]       out_ts,
    output logic [NT-1:0]        drop_flags,
    input  logic                 drop_clr,
    output logic [CW-1:0]        fifo_count
);

    localparam int AW  = clog2(DEPTH);
    localparam int EW  = entry_w(TRACEw, NT, TSw);
    localparam int TSL = ts_lsb();
    localparam int TLL = tile_lsb(TSw);
    localparam int TRL = trace_lsb(NT, TSw);

    logic [TSw-1:0]    ts_q, ts_d;
    logic [NT-1:0]     prev_q, prev_d;
    logic [NT-1:0]     hv_q, hv_d;
    logic [NT-1:0]     drop_q, drop_d;
    logic [NT-1:0]     ev, gnt;
    logic [TRACEw-1:0] htr_q [NT];
    logic [TRACEw-1:0] htr_d [NT];
    logic [TSw-1:0]    hts_q [NT];
    logic [TSw-1:0]    hts_d [NT];
    logic [EW-1:0]     mem_q [DEPTH];
    logic [EW-1:0]     mem_d [DEPTH];
    logic [AW-1:0]     wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              pop, allow, push;
    logic [TW-1:0]     gidx;
    logic [EW-1:0]     push_e, head;

    assign out_valid  = (cnt_q != '0);
    assign pop        = out_valid && out_ready;
    assign allow      = (cnt_q < CW'(DEPTH)) || pop;
    assign fifo_count = cnt_q;
    assign drop_flags = drop_q;

    // Head is forced to zero when empty so outputs read 0 out of reset.
    assign head      = out_valid ? mem_q[rd_q] : '0;
    assign out_ts    = head[TSL +: TSw];
    assign out_tile  = head[TLL +: TW];
    assign out_trace = head[TRL +: TRACEw];
    assign push_e    = {htr_q[gidx], gidx, hts_q[gidx]};

    trace_rr_arbiter #(.NT(NT)) u_arb (
        .clk       (clk),
        .reset     (reset),
        .req       (hv_q),
        .allow     (allow),
        .gnt       (gnt),
        .gnt_idx   (gidx),
        .gnt_valid (push)
    );

    // Event detection, either level or rising edge, and gated by en.
    always_comb begin
        ev = '0;
        if (en) ev = (EDGE_MODE != 0) ? (trigger_in & ~prev_q) : trigger_in;
    end

    // Timestamp, hold-register capture and release, and sticky drop flags.
    always_comb begin
        ts_d   = en ? ts_q + 1'b1 : ts_q;
        prev_d = trigger_in;
        hv_d   = hv_q;
        htr_d  = htr_q;
        hts_d  = hts_q;
        drop_d = drop_clr ? '0 : drop_q;
        for (int i = 0; i < NT; i++) begin
            if (gnt[i]) hv_d[i] = 1'b0;
            if (ev[i]) begin
                if (!hv_q[i] || gnt[i]) begin
                    hv_d[i]  = 1'b1;
                    htr_d[i] = trace_in[i*TRACEw +: TRACEw];
                    hts_d[i] = ts_q;
                end else begin
                    drop_d[i] = 1'b1;
                end
            end
        end
    end

    // FIFO pointers, occupancy and write port.
    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (push) begin
            mem_d[wr_q] = push_e;
            wr_d        = wr_q + 1'b1;
        end
        if (pop) rd_d = rd_q + 1'b1;
        if (push && !pop) cnt_d = cnt_q + 1'b1;
        if (pop && !push) cnt_d = cnt_q - 1'b1;
    end

    // State registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ts_q   <= '0;
            prev_q <= '0;
            hv_q   <= '0;
            drop_q <= '0;
            wr_q   <= '0;
            rd_q   <= '0;
            cnt_q  <= '0;
            for (int i = 0; i < NT; i++) begin
                htr_q[i] <= '0;
                hts_q[i] <= '0;
            end
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            ts_q   <= ts_d;
            prev_q <= prev_d;
            hv_q   <= hv_d;
            drop_q <= drop_d;
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            cnt_q  <= cnt_d;
            htr_q  <= htr_d;
            hts_q  <= hts_d;
            mem_q  <= mem_d;
        end
    end

endmodule

// File: tb/tb_noc_trace_collector.sv
// Scoreboard bench for noc_trace_collector (NT=4, DEPTH=8, TSw=4).
// Stimulus queues hand-computed entries; a negedge monitor checks pops.
module tb_noc_trace_collector;

    localparam int NT     = 4;
    localparam int TRACEw = 32;
    localparam int DEPTH  = 8;
    localparam int TSw    = 4;

    logic                 clk = 1'b0;
    logic                 reset, en, out_ready, drop_clr;
    logic [NT-1:0]        trigger_in;
    logic [NT*TRACEw-1:0] trace_in;
    logic                 out_valid;
    logic [TRACEw-1:0]    out_trace;
    logic [1:0]           out_tile;
    logic [TSw-1:0]       out_ts;
    logic [NT-1:0]        drop_flags;
    logic [3:0]           fifo_count;

    typedef struct packed {
        logic [31:0] tr;
        logic [1:0]  tile;
        logic [3:0]  ts;
    } ent_t;

    ent_t sb[$];
    int   checks = 0;
    int   errors = 0;

    noc_trace_collector #(
        .NT(NT), .TRACEw(TRACEw), .DEPTH(DEPTH), .TSw(TSw), .EDGE_MODE(0)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .trigger_in (trigger_in),
        .trace_in   (trace_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_trace  (out_trace),
        .out_tile   (out_tile),
        .out_ts     (out_ts),
        .drop_flags (drop_flags),
        .drop_clr   (drop_clr),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_tr(input int t, input logic [31:0] v);
        trace_in[t*TRACEw +: TRACEw] = v;
    endtask

    task automatic exp_push(input logic [31:0] tr, input logic [1:0] tile, input logic [3:0] ts);
        ent_t e;
        e.tr   = tr;
        e.tile = tile;
        e.ts   = ts;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        en         = 1'b0;
        out_ready  = 1'b0;
        drop_clr   = 1'b0;
        trigger_in = '0;
        trace_in   = '0;
        sb.delete();
        step();
        reset = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (n < 64 && (sb.size() != 0 || out_valid)) begin
            step();
            n++;
        end
        checks++;
        if (sb.size() != 0 || out_valid) begin
            errors++;
            $display("FAIL %s: drain timeout, %0d entries left, out_valid=%0b", name, sb.size(), out_valid);
        end
    endtask

    // Monitor: compare every accepted head against the scoreboard.
    always @(negedge clk) begin
        ent_t e;
        if (!reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pop: got tile %0d ts %0d trace %0h, required none",
                         out_tile, out_ts, out_trace);
            end else begin
                e = sb.pop_front();
                chk("out_trace", 64'(out_trace), 64'(e.tr));
                chk("out_tile", 64'(out_tile), 64'(e.tile));
                chk("out_ts", 64'(out_ts), 64'(e.ts));
            end
        end
    end

    initial begin
        int n;
        reset = 1'b1;
        en = 1'b0;
        out_ready = 1'b0;
        drop_clr = 1'b0;
        trigger_in = '0;
        trace_in = '0;

        // Reset state, then a single event with ts=5 and minimum latency.
        do_reset();
        chk("rst_valid", 64'(out_valid), 0);
        chk("rst_count", 64'(fifo_count), 0);
        chk("rst_drop", 64'(drop_flags), 0);
        chk("rst_head", {out_trace, 26'd0, out_tile, out_ts}, 0);
        en = 1'b1;
        out_ready = 1'b1;
        repeat (5) step();
        set_tr(2, 32'hDEADBEEF);
        trigger_in = 4'b0100;
        exp_push(32'hDEADBEEF, 2'd2, 4'd5);
        step();
        trigger_in = '0;
        chk("lat_edge_t", 64'(out_valid), 0);
        step();
        chk("lat_edge_t1", 64'(out_valid), 1);
        drain("single");

        // Round-robin: all tiles at once, then the pointer must be back at 0.
        do_reset();
        en = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < NT; i++) begin
            set_tr(i, 32'hA000_0000 + i);
            exp_push(32'hA000_0000 + i, 2'(i), 4'd0);
        end
        trigger_in = 4'b1111;
        step();
        trigger_in = '0;
        chk("rr_first", 64'(out_valid), 0);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("rr_consecutive", 64'(out_valid), 1);
        end
        step();
        chk("rr_empty", 64'(out_valid), 0);
        set_tr(0, 32'hB000_0000);
        set_tr(3, 32'hB000_0003);
        trigger_in = 4'b1001;
        exp_push(32'hB000_0000, 2'd0, 4'd6);
        exp_push(32'hB000_0003, 2'd3, 4'd6);
        step();
        trigger_in = '0;
        drain("rr_ptr");

        // Overflow: tile 1 held high for 12 cycles while the FIFO is blocked.
        do_reset();
        en = 1'b1;
        for (int i = 0; i < 12; i++) begin
            set_tr(1, 32'h1000_0000 + i);
            trigger_in = 4'b0010;
            if (i < 8) exp_push(32'h1000_0000 + i, 2'd1, 4'(i));
            step();
            if (i == 8) begin
                chk("ovf_count_full", 64'(fifo_count), 8);
                chk("ovf_no_drop_yet", 64'(drop_flags), 0);
            end
        end
        trigger_in = '0;
        chk("ovf_count", 64'(fifo_count), 8);
        chk("ovf_drop", 64'(drop_flags), 4'b0010);

        // A drop_clr that coincides with a new drop on tile 3 leaves only bit 3 set.
        set_tr(3, 32'hCAFE_0003);
        trigger_in = 4'b1000;
        step();
        drop_clr = 1'b1;
        step();
        drop_clr = 1'b0;
        trigger_in = '0;
        chk("clr_prio", 64'(drop_flags), 4'b1000);
        chk("clr_count", 64'(fifo_count), 8);
        exp_push(32'hCAFE_0003, 2'd3, 4'd12);
        exp_push(32'h1000_0008, 2'd1, 4'd8);
        out_ready = 1'b1;
        drain("ovf");

        // Timestamp wraps 15 to 0; with en=0 there is no capture, but the FIFO still drains.
        do_reset();
        en = 1'b1;
        out_ready = 1'b1;
        repeat (15) step();
        set_tr(0, 32'hE000_000F);
        trigger_in = 4'b0001;
        exp_push(32'hE000_000F, 2'd0, 4'd15);
        step();
        set_tr(0, 32'hE000_0000);
        exp_push(32'hE000_0000, 2'd0, 4'd0);
        step();
        trigger_in = '0;
        repeat (3) step();
        out_ready = 1'b0;
        set_tr(1, 32'hE000_0001);
        set_tr(2, 32'hE000_0002);
        trigger_in = 4'b0110;
        exp_push(32'hE000_0001, 2'd1, 4'd4);
        exp_push(32'hE000_0002, 2'd2, 4'd4);
        step();
        en = 1'b0;
        set_tr(0, 32'hEEEE_EEEE);
        trigger_in = 4'b0001;
        repeat (3) step();
        trigger_in = '0;
        chk("en0_count", 64'(fifo_count), 2);
        out_ready = 1'b1;
        drain("en0");
        en = 1'b1;
        set_tr(3, 32'hE000_0003);
        trigger_in = 4'b1000;
        exp_push(32'hE000_0003, 2'd3, 4'd5);
        step();
        trigger_in = '0;
        drain("ts_hold");

        // Asynchronous reset with 5 entries queued and drop flags set.
        do_reset();
        en = 1'b1;
        for (int i = 0; i < NT; i++) set_tr(i, 32'hF000_0000 + i);
        trigger_in = 4'b1111;
        step();
        step();
        trigger_in = '0;
        n = 0;
        while (n < 20 && fifo_count != 4'd5) begin
            step();
            n++;
        end
        chk("pre_rst_count", 64'(fifo_count), 5);
        chk("pre_rst_drop", 64'(drop_flags), 4'b1110);
        reset = 1'b1;
        #2;
        chk("async_valid", 64'(out_valid), 0);
        chk("async_count", 64'(fifo_count), 0);
        chk("async_drop", 64'(drop_flags), 0);
        chk("async_head", {out_trace, 26'd0, out_tile, out_ts}, 0);
        sb.delete();
        step();
        reset = 1'b0;
        out_ready = 1'b1;
        repeat (3) step();
        chk("post_rst_empty", 64'(out_valid), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/noc_trace_collector.md
NOC_TRACE_COLLECTOR -- requirements
Module: noc_trace_collector

Interface
REQ-001 SHALL have parameter NT, default 4: number of tiles driving trace, 2..16.
REQ-002 SHALL have parameter TRACEw, default 32: trace word width.
REQ-003 SHALL have parameter DEPTH, default 8: output FIFO entries, power of two, at least 2.
REQ-004 SHALL have parameter TSw, default 16: timestamp width.
REQ-005 SHALL have parameter EDGE_MODE, default 0: 0 means a high trigger is an event every cycle; 1 means only a trigger rising edge is an event.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all state is on its rising edge.
REQ-007 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-008 SHALL have port en, input, 1 bit: capture and timestamp enable.
REQ-009 SHALL have port trigger_in, input, NT bits: per-tile trigger, bit i is tile i.
REQ-010 SHALL have port trace_in, input, NT*TRACEw bits: tile i occupies bits [(i+1)*TRACEw-1 : i*TRACEw].
REQ-011 SHALL have port out_valid, output, 1 bit: FIFO head valid.
REQ-012 SHALL have port out_ready, input, 1 bit: consumer accepts head.
REQ-013 SHALL have port out_trace, output, TRACEw bits: head trace word.
REQ-014 SHALL have port out_tile, output, log2(NT) bits: head source tile.
REQ-015 SHALL have port out_ts, output, TSw bits: head capture timestamp.
REQ-016 SHALL have port drop_flags, output, NT bits: sticky per-tile overflow flags.
REQ-017 SHALL have port drop_clr, input, 1 bit: clears all drop_flags.
REQ-018 SHALL have port fifo_count, output, log2(DEPTH)+1 bits: current FIFO occupancy.

Function
REQ-019 SHALL keep a free-running timestamp counter that increments by 1 per cycle while en=1, holds while en=0, and wraps from 2^TSw-1 to 0.
REQ-020 SHALL capture an event of tile i only while en=1; on capture it loads hold register i with {trace_in slice i, current timestamp} and sets hold_valid[i].
REQ-021 SHALL accept an event into hold register i if hold_valid[i]=0, or if hold i is granted in the same cycle; otherwise it drops the event and sets drop_flags[i].
REQ-022 SHALL have drop_clr clear all drop_flags; when a set and drop_clr coincide on a bit, the set wins.
REQ-023 SHALL run a round-robin arbiter over hold_valid that grants at most one tile per cycle, and only when push is permitted (REQ-024).
REQ-024 SHALL permit a push when fifo_count<DEPTH, or when fifo_count=DEPTH and a pop occurs in the same cycle.
REQ-025 SHALL start the arbiter search at the pointer, with lowest index first from the pointer and wrapping from NT-1 to 0.
REQ-026 SHALL set the arbiter pointer to granted+1 (mod NT) after a grant; the pointer is unchanged when there is no grant.
REQ-027 SHALL, on a grant, push {trace, tile index, ts} into the FIFO and clear hold_valid of the granted tile, unless a new event reloads that hold register in the same cycle.
REQ-028 SHALL pop the FIFO when out_valid && out_ready, with out_valid = (fifo_count != 0).
REQ-029 SHALL drive out_trace, out_tile and out_ts from the FIFO head, stable while out_valid=1 and out_ready=0.
REQ-030 SHALL give a minimum latency, with an empty system and out_ready=1, of: event sampled at edge t, hold_valid after edge t, push at edge t+1, out_valid high after edge t+1.
REQ-031 SHALL update fifo_count as +1 on push only, -1 on pop only, and unchanged on simultaneous push and pop; it never exceeds DEPTH and never underflows.
REQ-032 SHALL keep draining FIFO and hold registers normally while en=0.
REQ-033 SHALL, in EDGE_MODE=1, hold a per-tile previous-trigger register that updates every cycle regardless of en.

Reset
REQ-034 SHALL, on reset, asynchronously zero the timestamp, hold_valid, hold data, drop_flags, arbiter pointer, FIFO pointers, fifo_count and the previous-trigger register.
REQ-035 SHALL hold out_valid=0 and out_trace/out_tile/out_ts=0 during and after reset until the first push.
REQ-036 SHALL discard any in-flight events on reset mid-operation.

Structure
REQ-037 SHALL take the log2 function, the entry width (TRACEw+log2(NT)+TSw) and the field offsets from a shared trace package/header.
REQ-038 SHALL implement the arbiter as sub-module trace_rr_arbiter (NT requests, one-hot grant, pointer update).
REQ-039 SHALL implement the FIFO inline as a register array with wrap-around read/write pointers.

Verification
REQ-040 SHALL cover a single event: tile 2 trigger 1 cycle, trace 0xDEADBEEF, ts=5 at capture -> after 2 edges out_valid=1, out_tile=2, out_trace=0xDEADBEEF, out_ts=5.
REQ-041 SHALL cover round-robin order: all 4 tiles trigger in one cycle, pointer=0, out_ready=1 -> outputs in tile order 0,1,2,3 on consecutive cycles, and the pointer ends at 0.
REQ-042 SHALL cover overflow: out_ready=0 and EDGE_MODE=0 with tile 1 trigger held high for 12 cycles, DEPTH=8 -> fifo_count reaches 8, drop_flags[1]=1, and the first 8 entries hold ts values 0..7 in order.
REQ-043 SHALL cover drop_clr priority: drop_clr asserted in the same cycle as a new drop on tile 3 -> drop_flags[3] stays 1 and all other bits clear.
REQ-044 SHALL cover timestamp wrap and en: TSw=4, run 20 cycles with en=1 then en=0 -> ts wraps 15->0, no captures while en=0, and queued entries still drain.
REQ-045 SHALL cover reset mid-operation: assert reset with 5 entries queued -> out_valid=0, fifo_count=0 and drop_flags=0 immediately, without waiting for a clock edge.
